adc_data_format: RTL and testbench

ADC_DATA_FORMAT -- requirements
Module: adc_data_format

---
 rtl/adc_fmt_pkg.sv | 13 +
 rtl/adc_sample_sat.sv | 35 +++
 rtl/adc_data_format.sv | 144 ++++++++++++++
 tb/tb_adc_data_format.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fmt_pkg.sv
// Shared definitions for the ADC sample formatter: valid-controller states and pipeline depth.
// Pipeline depth doubles as the flush length after a format or offset change.
package adc_fmt_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        FLUSH  = 2'd1,
        RUN    = 2'd2
    } vldState_t;

    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/adc_sample_sat.sv
// One sample lane: subtract the channel offset at one extra bit, clamp to the sample range, register.
// One cycle latency; satHit flags the clamp combinationally in the same cycle.
module adc_sample_sat #(
    parameter int SAMPLE_W = 10
) (
    input  logic                clk_div_a,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sampleIn,
    input  logic [SAMPLE_W-1:0] offsetIn,
    output logic [SAMPLE_W-1:0] sampleOut,
    output logic                satHit
);

    logic signed [SAMPLE_W:0] diff;
    logic        [SAMPLE_W-1:0] satVal;

    always_comb begin
        diff   = $signed({sampleIn[SAMPLE_W-1], sampleIn}) - $signed({offsetIn[SAMPLE_W-1], offsetIn});
        // top two bits disagree only when the difference left the SAMPLE_W range
        satHit = diff[SAMPLE_W] ^ diff[SAMPLE_W-1];
        satVal = diff[SAMPLE_W-1:0];
        if (satHit) begin
            satVal = diff[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            sampleOut <= '0;
        end else begin
            sampleOut <= satVal;
        end
    end

endmodule

// File: rtl/adc_data_format.sv
// ADC sample formatter: offset-binary/two's-complement conversion, offset removal with saturation,
// sticky per-channel saturation flags; 3-cycle latency, one sample set per cycle, no backpressure.
module adc_data_format
    import adc_fmt_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SERDES_RATIO  = 4,
    parameter int SAMPLE_W      = 10,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                                     clk_div_a,
    input  logic                                     rst,
    input  logic [NUM_CH*SERDES_RATIO*SAMPLE_W-1:0]  data_in,
    input  logic                                     fmt_mode,
    input  logic [NUM_CH*SAMPLE_W-1:0]               offset_in,
    input  logic                                     offset_load,
    input  logic                                     sat_clr,
    output logic [NUM_CH*SERDES_RATIO*SAMPLE_W-1:0]  data_out,
    output logic                                     data_valid,
    output logic [NUM_CH-1:0]                        sat_flag
);

    localparam int NUM_S = NUM_CH * SERDES_RATIO;
    localparam int DW    = NUM_S * SAMPLE_W;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    logic [DW-1:0]              stage1Q;
    logic [DW-1:0]              stage2Q;
    logic [NUM_CH*SAMPLE_W-1:0] offsetQ;
    logic [NUM_S-1:0]           satHit;
    logic [NUM_CH-1:0]          satNow;
    logic                       fmtModeQ;
    logic                       trigger;
    vldState_t                  state;
    logic [CNT_W-1:0]           cnt;

    // Flipping the MSB of an offset-binary code yields its two's-complement value.
    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            stage1Q <= '0;
        end else begin
            for (int i = 0; i < NUM_S; i++) begin
                stage1Q[i*SAMPLE_W +: SAMPLE_W] <= {data_in[i*SAMPLE_W + SAMPLE_W - 1] ^ fmt_mode,
                                                    data_in[i*SAMPLE_W +: SAMPLE_W-1]};
            end
        end
    end

    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            offsetQ <= '0;
        end else if (offset_load) begin
            offsetQ <= offset_in;
        end
    end

    for (genvar i = 0; i < NUM_S; i++) begin : gSample
        adc_sample_sat #(
            .SAMPLE_W (SAMPLE_W)
        ) uSat (
            .clk_div_a (clk_div_a),
            .rst       (rst),
            .sampleIn  (stage1Q[i*SAMPLE_W +: SAMPLE_W]),
            .offsetIn  (offsetQ[(i/SERDES_RATIO)*SAMPLE_W +: SAMPLE_W]),
            .sampleOut (stage2Q[i*SAMPLE_W +: SAMPLE_W]),
            .satHit    (satHit[i])
        );
    end

    always_comb begin
        satNow = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < SERDES_RATIO; s++) begin
                satNow[c] = satNow[c] | satHit[c*SERDES_RATIO + s];
            end
        end
    end

    // A fresh saturation outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            sat_flag <= '0;
        end else begin
            sat_flag <= (sat_clr ? '0 : sat_flag) | satNow;
        end
    end

    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= stage2Q;
        end
    end

    assign trigger = offset_load | (fmt_mode ^ fmtModeQ);

    always_ff @(posedge clk_div_a or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            cnt        <= '0;
            data_valid <= 1'b0;
            fmtModeQ   <= 1'b0;
        end else begin
            fmtModeQ <= fmt_mode;
            case (state)
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state      <= RUN;
                        cnt        <= '0;
                        data_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (trigger) begin
                        state      <= FLUSH;
                        cnt        <= '0;
                        data_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    // any new disturbance restarts the drain of stale samples
                    if (trigger) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(PIPE_LAT - 1)) begin
                        state      <= RUN;
                        cnt        <= '0;
                        data_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= SETTLE;
                    cnt        <= '0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_data_format.sv
// Randomized and directed checks of adc_data_format against an arithmetic reference model.
module tb_adc_data_format;

    localparam int NCH = 4;
    localparam int SR  = 4;
    localparam int SW  = 10;
    localparam int DW  = NCH * SR * SW;

    logic            clk_div_a = 1'b0;
    logic            rst;
    logic [DW-1:0]   data_in;
    logic            fmt_mode;
    logic [NCH*SW-1:0] offset_in;
    logic            offset_load;
    logic            sat_clr;
    logic [DW-1:0]   data_out;
    logic            data_valid;
    logic [NCH-1:0]  sat_flag;

    int passCnt = 0;
    int failCnt = 0;

    // reference model state
    logic [DW-1:0] expQ[$];
    int            mOff[NCH];
    int            edges;
    int            lastTrig;
    logic          prevFmt;

    adc_data_format #(
        .NUM_CH        (NCH),
        .SERDES_RATIO  (SR),
        .SAMPLE_W      (SW),
        .SETTLE_CYCLES (16)
    ) dut (
        .clk_div_a   (clk_div_a),
        .rst         (rst),
        .data_in     (data_in),
        .fmt_mode    (fmt_mode),
        .offset_in   (offset_in),
        .offset_load (offset_load),
        .sat_clr     (sat_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sat_flag    (sat_flag)
    );

    always #5 clk_div_a = ~clk_div_a;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        assert (obs === exp) begin
            passCnt++;
        end else begin
            failCnt++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rndData();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Sample value as a signed integer, minus offset, clamped to the 10-bit signed range.
    function automatic logic [SW-1:0] refSample(input logic [SW-1:0] raw, input logic fmt, input int off);
        int v;
        if (fmt) v = int'(raw) - 512;
        else     v = (raw >= 10'd512) ? int'(raw) - 1024 : int'(raw);
        v = v - off;
        if (v > 511)  v = 511;
        if (v < -512) v = -512;
        return v[SW-1:0];
    endfunction

    task automatic modelReset();
        edges    = 0;
        lastTrig = -100;
        prevFmt  = 1'b0;
        for (int c = 0; c < NCH; c++) mOff[c] = 0;
        expQ.delete();
    endtask

    // One clock cycle with the currently driven inputs; checks data_out and data_valid afterwards.
    task automatic tick();
        logic [DW-1:0] e;
        logic [SW-1:0] raw;
        logic          trig;
        logic          expValid;
        e    = '0;
        trig = offset_load || (fmt_mode != prevFmt);
        if (offset_load) begin
            for (int c = 0; c < NCH; c++) mOff[c] = $signed(offset_in[c*SW +: SW]);
        end
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < SR; s++) begin
                raw = data_in[(c*SR + s)*SW +: SW];
                e[(c*SR + s)*SW +: SW] = refSample(raw, fmt_mode, mOff[c]);
            end
        end
        expQ.push_back(e);
        if (trig && edges >= 16) lastTrig = edges;
        prevFmt = fmt_mode;
        @(posedge clk_div_a);
        #1;
        edges++;
        if (expQ.size() == 3) chk("data_out", data_out, expQ.pop_front());
        expValid = (edges >= 16) && !(lastTrig >= 16 && edges <= lastTrig + 3);
        chk("data_valid", DW'(data_valid), DW'(expValid));
        offset_load = 1'b0;
        sat_clr     = 1'b0;
    endtask

    task automatic waitValid(input string tag, output int n);
        n = 0;
        while (!data_valid && n < 50) begin
            data_in = rndData();
            tick();
            n++;
        end
        chk(tag, DW'(data_valid), DW'(1'b1));
    endtask

    initial begin
        int n;
        logic [DW-1:0] d;

        rst         = 1'b1;
        data_in     = '0;
        fmt_mode    = 1'b1;
        offset_in   = '0;
        offset_load = 1'b0;
        sat_clr     = 1'b0;
        repeat (2) @(posedge clk_div_a);
        #1;
        chk("rst_data_out", data_out, '0);
        chk("rst_valid", DW'(data_valid), '0);
        chk("rst_sat_flag", DW'(sat_flag), '0);
        rst = 1'b0;
        modelReset();

        waitValid("settle_done", n);
        chk("settle_len", DW'(n), DW'(16));

        // offset-binary extremes and midpoint
        d = '0;
        d[19:10] = 10'd512;
        d[29:20] = 10'd1023;
        data_in = d;
        tick();
        data_in = rndData();
        tick();
        tick();
        chk("ob_zero", DW'(data_out[9:0]), DW'(10'h200));
        chk("ob_mid", DW'(data_out[19:10]), DW'(10'h000));
        chk("ob_full", DW'(data_out[29:20]), DW'(10'h1FF));

        // positive offset drives channel 0 below the minimum
        offset_in   = {30'd0, 10'd4};
        offset_load = 1'b1;
        data_in     = '0;
        repeat (4) tick();
        chk("neg_sat_out", DW'(data_out[9:0]), DW'(10'h200));
        chk("neg_sat_flag", DW'(sat_flag), DW'(4'b0001));
        data_in = {16{10'd512}};
        repeat (3) tick();
        sat_clr = 1'b1;
        tick();
        chk("sat_clr", DW'(sat_flag), DW'(4'b0000));
        data_in = '0;
        tick();
        data_in = {16{10'd512}};
        sat_clr = 1'b1;
        tick();
        chk("set_wins", DW'(sat_flag), DW'(4'b0001));
        repeat (2) tick();
        sat_clr = 1'b1;
        tick();
        chk("sat_clr2", DW'(sat_flag), DW'(4'b0000));

        // negative offset pushes the top code above the maximum
        offset_in   = {30'd0, 10'h3FC};
        offset_load = 1'b1;
        d = {16{10'd512}};
        d[9:0]   = 10'd1023;
        d[19:10] = 10'd600;
        data_in = d;
        tick();
        data_in = {16{10'd512}};
        tick();
        tick();
        chk("pos_sat_out", DW'(data_out[9:0]), DW'(10'h1FF));
        chk("off_sub_out", DW'(data_out[19:10]), DW'(10'd92));
        chk("pos_sat_flag", DW'(sat_flag[0]), DW'(1'b1));

        // single and back-to-back offset loads
        waitValid("valid_pre_load", n);
        offset_in   = '0;
        offset_load = 1'b1;
        n = 0;
        tick();
        while (!data_valid && n < 20) begin
            n++;
            tick();
        end
        chk("single_load_drop", DW'(n), DW'(3));
        offset_load = 1'b1;
        n = 0;
        tick();
        if (!data_valid) n++;
        offset_load = 1'b1;
        tick();
        while (!data_valid && n < 20) begin
            n++;
            tick();
        end
        chk("double_load_drop", DW'(n), DW'(4));

        // switch to two's-complement input
        fmt_mode = 1'b0;
        data_in  = {16{10'h3FF}};
        n = 0;
        tick();
        while (!data_valid && n < 20) begin
            n++;
            tick();
        end
        chk("fmt_flush_len", DW'(n), DW'(3));
        chk("tc_passthru", DW'(data_out[9:0]), DW'(10'h3FF));

        // randomized traffic with format flips, offset reloads and clears
        for (int i = 0; i < 400; i++) begin
            data_in = rndData();
            if ($urandom_range(15) == 0) fmt_mode = ~fmt_mode;
            if ($urandom_range(19) == 0) begin
                offset_in   = ($urandom_range(1) == 0) ? {$urandom(), $urandom()} : {4{10'($urandom_range(15)) - 10'd8}};
                offset_load = 1'b1;
            end
            if ($urandom_range(7) == 0) sat_clr = 1'b1;
            tick();
        end

        // asynchronous reset mid-stream with a flag set and valid high
        fmt_mode    = 1'b1;
        offset_in   = {30'd0, 10'd4};
        offset_load = 1'b1;
        data_in     = '0;
        repeat (3) tick();
        waitValid("valid_pre_rst", n);
        chk("sat_pre_rst", DW'(sat_flag[0]), DW'(1'b1));
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data_out", data_out, '0);
        chk("arst_valid", DW'(data_valid), '0);
        chk("arst_sat_flag", DW'(sat_flag), '0);
        @(posedge clk_div_a);
        #1;
        rst = 1'b0;
        modelReset();
        waitValid("resettle_done", n);
        chk("resettle_len", DW'(n), DW'(16));

        $display("%0d/%0d checks passed", passCnt, passCnt + failCnt);
        $finish;
    end

endmodule
